// File: rtl/hex_pkg.sv
// rtl/hex_pkg.sv - shared widths, blank code and active-low hex segment table
package hex_pkg;

  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 4;

  // All segments off (active-low)
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns; index 15 is leftmost
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [DIGIT_W-1:0] digit);
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/hex_digit_seg.sv
// rtl/hex_digit_seg.sv - registered single-digit hex to 7-segment decoder with blank
module hex_digit_seg
  import hex_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg
);

  // Register the decoded pattern; reset shows "0" so the display is never dark
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= hex_to_seg(4'h0);
    end else if (blank) begin
      seg <= SEG_BLANK;
    end else begin
      seg <= hex_to_seg(digit);
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - N-digit hex counter/display with LZ blanking, blink and wrap flag
module hex_display_ctrl
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                          CLOCK_50,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] data,
  input  logic                          inc,
  input  logic                          blank_lz,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic [SEG_W*NUM_DIGITS-1:0]   segs,
  output logic [DIGIT_W*NUM_DIGITS-1:0] value,
  output logic                          wrap
);

  localparam int VAL_W = DIGIT_W * NUM_DIGITS;
  localparam int PS_W  = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  if (BLINK_DIV < 2) begin : g_bad_blink_div
    $error("hex_display_ctrl: BLINK_DIV must be >= 2");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("hex_display_ctrl: NUM_DIGITS must be 1..8");
  end

  logic [PS_W-1:0]       prescaler;
  logic                  blink_phase;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [NUM_DIGITS-1:0] digit_blank;
  logic                  upper_zero;

  // Held value with clr > load > inc priority; wrap flags an accepted all-F increment
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      value <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= inc & ~clr & ~load & (&value);
      if (clr) begin
        value <= '0;
      end else if (load) begin
        value <= data;
      end else if (inc) begin
        value <= value + VAL_W'(1);
      end
    end
  end

  // Free-running blink prescaler; phase toggles each time it passes terminal count
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      prescaler   <= '0;
      blink_phase <= 1'b0;
    end else if (prescaler == PS_W'(BLINK_DIV - 1)) begin
      prescaler   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      prescaler <= prescaler + PS_W'(1);
    end
  end

  // Leading-zero blank: scan from the top digit down; digit 0 always stays lit
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero & (value[DIGIT_W*i +: DIGIT_W] == '0);
      lz_blank[i] = blank_lz & upper_zero & (i != 0);
    end
  end

  assign digit_blank = lz_blank | (blink_mask & {NUM_DIGITS{blink_phase}});

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    hex_digit_seg u_digit (
      .clk   (CLOCK_50),
      .rst_n (rst_n),
      .digit (value[DIGIT_W*i +: DIGIT_W]),
      .blank (digit_blank[i]),
      .seg   (segs[SEG_W*i +: SEG_W])
    );
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - table-driven and sequence checks for hex_display_ctrl
module tb_hex_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;

  logic        CLOCK_50 = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic        inc = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  blink_mask = '0;
  logic [55:0] segs;
  logic [31:0] value;
  logic        wrap;

  int checks = 0;
  int failures = 0;

  hex_display_ctrl #(.NUM_DIGITS(8), .BLINK_DIV(4)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .clr        (clr),
    .load       (load),
    .data       (data),
    .inc        (inc),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .segs       (segs),
    .value      (value),
    .wrap       (wrap)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [31:0] data;
    logic        blz;
    logic [55:0] exp_segs;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [55:0] pk8(input logic [6:0] d7, d6, d5, d4, d3, d2, d1, d0);
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  function automatic logic [6:0] dig(input int i);
    return segs[7*i +: 7];
  endfunction

  initial begin
    int n;
    vecs[0] = '{32'h0000_A5C1, 1'b0, pk8(S0, S0, S0, S0, SA, S5, SC, S1)};
    vecs[1] = '{32'h0000_A5C1, 1'b1, pk8(BL, BL, BL, BL, SA, S5, SC, S1)};
    vecs[2] = '{32'h89AB_CDEF, 1'b0, pk8(S8, S9, SA, SB, SC, SD, SE, SF)};
    vecs[3] = '{32'h0123_4567, 1'b1, pk8(BL, S1, S2, S3, S4, S5, S6, S7)};
    vecs[4] = '{32'h0000_0000, 1'b1, pk8(BL, BL, BL, BL, BL, BL, BL, S0)};
    vecs[5] = '{32'h0010_0000, 1'b1, pk8(BL, BL, S1, S0, S0, S0, S0, S0)};

    // Reset held 3 cycles with load asserted
    load = 1'b1;
    data = 32'hDEAD_BEEF;
    repeat (3) step();
    chk("reset_value", 64'(value), 64'h0);
    chk("reset_segs", 64'(segs), 64'(pk8(S0, S0, S0, S0, S0, S0, S0, S0)));
    chk("reset_wrap", 64'(wrap), 64'h0);
    load = 1'b0;
    rst_n = 1'b1;

    // Table-driven load/decode vectors
    for (int v = 0; v < 6; v++) begin
      blank_lz = vecs[v].blz;
      data = vecs[v].data;
      load = 1'b1;
      step();
      load = 1'b0;
      chk($sformatf("vec%0d_value", v), 64'(value), 64'(vecs[v].data));
      step();
      chk($sformatf("vec%0d_segs", v), 64'(segs), 64'(vecs[v].exp_segs));
    end

    // Wrap: FFFFFFFE + 2 increments
    blank_lz = 1'b1;
    data = 32'hFFFF_FFFE;
    load = 1'b1;
    step();
    load = 1'b0;
    inc = 1'b1;
    step();
    chk("wrap_val1", 64'(value), 64'hFFFF_FFFF);
    chk("wrap_flag1", 64'(wrap), 64'h0);
    step();
    inc = 1'b0;
    chk("wrap_val2", 64'(value), 64'h0);
    chk("wrap_flag2", 64'(wrap), 64'h1);
    step();
    chk("wrap_flag3", 64'(wrap), 64'h0);
    chk("wrap_segs", 64'(segs), 64'(pk8(BL, BL, BL, BL, BL, BL, BL, S0)));

    // Priority: clr > load > inc, and no wrap when inc loses
    data = 32'hFFFF_FFFF;
    load = 1'b1;
    step();
    chk("prio_pre", 64'(value), 64'hFFFF_FFFF);
    data = 32'h0000_1234;
    clr = 1'b1;
    inc = 1'b1;
    step();
    clr = 1'b0;
    chk("prio_clr", 64'(value), 64'h0);
    chk("prio_nowrap", 64'(wrap), 64'h0);
    step();
    load = 1'b0;
    inc = 1'b0;
    chk("prio_load", 64'(value), 64'h0000_1234);
    chk("prio_nowrap2", 64'(wrap), 64'h0);

    // Blink on digit 1 with value 0x88
    blank_lz = 1'b0;
    blink_mask = 8'b0000_0010;
    data = 32'h0000_0088;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    n = 0;
    while (dig(1) === BL && n < 20) begin step(); n++; end
    chk("blink_find_vis", 64'(n < 20), 64'h1);
    n = 0;
    while (dig(1) !== BL && n < 20) begin step(); n++; end
    chk("blink_find_blank", 64'(n < 20), 64'h1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("blink_d1_%0d", k), 64'(dig(1)), 64'((k < 4 || k >= 8) ? BL : S8));
      chk($sformatf("blink_d0_%0d", k), 64'(dig(0)), 64'(S8));
      if (k < 9) step();
    end

    // Reset in the middle of a blank half-period
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("rblink_d1_%0d", k), 64'(dig(1)), 64'((k >= 5 && k <= 8) ? BL : S0));
      step();
    end
    chk("rblink_value", 64'(value), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Parametrised N-digit hex display controller; successor to the fixed switch-to-HEX decoding on the DE2 top.
- Holds a display value, loaded in parallel or advanced as a hex up-counter, and drives N active-low 7-segment digits.
- Adds leading-zero blanking, per-digit blink from an internal prescaler, and a wrap flag.
- Instantiated in top between the SW/KEY inputs and HEX0..HEX(N-1).

Parameters:
- NUM_DIGITS, 8, number of hex digits displayed (1..8).
- BLINK_DIV, 25000000, CLOCK_50 cycles per blink half-period; must be >= 2 (elaboration error otherwise).

Ports:
- CLOCK_50  in   1  system clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clr  in  1  clear value to 0.
- load  in  1  capture data into value.
- data  in  4*NUM_DIGITS  parallel load value; digit i = data[4i+3:4i].
- inc  in  1  increment value by 1.
- blank_lz  in  1  enable leading-zero blanking.
- blink_mask  in  NUM_DIGITS  bit i set: digit i blinks.
- segs  out  7*NUM_DIGITS  digit i = segs[7i+6:7i], bit order {g,f,e,d,c,b,a}, active-low.
- value  out  4*NUM_DIGITS  current held value.
- wrap  out  1  one-cycle pulse when inc rolls value from all-F to 0.

Behaviour:
- Reset (rst_n low at a clock edge):
  - value = 0, prescaler = 0, blink_phase = 0, wrap = 0.
  - segs = 7'b1000000 on every digit, regardless of blank_lz.
  - Reset dominates any other input. Reset mid-count or mid-blink restarts the prescaler at 0 with the phase visible.
- Value update priority per cycle is clr > load > inc.
  - clr: value <= 0.
  - load: value <= data.
  - inc alone: value <= (value + 1) mod 2^(4*NUM_DIGITS).
  - None asserted: value holds.
- wrap is registered. It is 1 in the cycle after an accepted inc with value all-F (value becomes 0); otherwise 0. No wrap when load or clr wins over inc.
- Latency:
  - value updates 1 cycle after the command.
  - segs update 1 cycle after value, so 2 cycles from load/inc/clr to segs.
  - blank_lz, blink_mask and blink_phase are sampled into the segs register: 1-cycle latency.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank = 1111111.
- Leading-zero blanking (blank_lz=1):
  - Digit i is blank if value digits i..NUM_DIGITS-1 are all zero and i > 0.
  - Digit 0 is never LZ-blanked; value 0 shows a single "0".
- Blink:
  - The prescaler counts 0..BLINK_DIV-1 continuously.
  - At terminal count it returns to 0 and blink_phase toggles.
  - While blink_phase=1, digits with blink_mask[i]=1 are blank.
  - Digit blank = LZ-blank OR blink-blank.
- Simultaneous inc and terminal count: independent; both take effect.
- NUM_DIGITS=1: blank_lz has no effect; wrap on F->0.

Decomposition:
- Shared package hex_pkg holds:
  - SEG_W=7 and DIGIT_W=4;
  - SEG_BLANK constant;
  - the 16-entry active-low segment table as a constant array;
  - function hex_to_seg.
- One sub-module, hex_digit_seg: registered single-digit decoder with a blank input, generated NUM_DIGITS times.
- Counter, prescaler and blanking logic stay in hex_display_ctrl.

Test Plan:
- Reset with NUM_DIGITS=8, BLINK_DIV=4 -> segs all digits 7'b1000000, value=0, wrap=0. Hold rst_n low 3 cycles while load=1 -> value stays 0.
- load=1, data=32'h0000_A5C1 -> 2 cycles later:
  - digit0=1111001, digit1=1000110, digit2=0010010, digit3=0001000;
  - digits4..7=1000000 with blank_lz=0, and 1111111 with blank_lz=1.
- load data=32'hFFFF_FFFE, then inc 2 cycles:
  - value FFFFFFFF then 00000000;
  - wrap high exactly 1 cycle, after the second inc;
  - with blank_lz=1, segs show only digit0=1000000.
- clr, load and inc together with data=32'h1234 -> value=0. Then load and inc together with data=32'h1234 -> value=0x1234 (no increment).
- BLINK_DIV=4, blink_mask=8'b0000_0010, value=0x88:
  - digit1 alternates 0000000 / 1111111 every 4 cycles;
  - digit0 stays 0000000.
  - Assert rst_n low mid-blank -> digit1 visible after reset, next blank 4 cycles later.
